cell_pos_reader: RTL and testbench

Streaming read sequencer that sits directly downstream of a per-cell position memory (single-port RAM, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz, posy, posx}). On a start pulse it reads the particle count, then issues one read per particle and delivers the positions as a valid/ready stream to the force-evaluation pipeline. Backpressure is absorbed with a credit-controlled output FIFO, so no read result is ever dropped.

---
 rtl/cell_pos_reader.sv | 162 ++++++++++++++++
 tb/tb_cell_pos_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_pos_reader.sv
// Streams the particle positions of one cell out of a 2-cycle-latency position RAM.
// Reads the count at address 0, then issues credit-limited reads into an output FIFO.
module cell_pos_reader #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_num,
  output logic [ADDR_WIDTH-1:0] cell_address,
  output logic                  cell_rden,
  output logic                  cell_wren,
  input  logic [DATA_WIDTH-1:0] cell_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW+1:0] DEPTH_V  = (CW+2)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, RD_NUM, WAIT_NUM, STREAM, DRAIN} state_t;

  state_t                state;
  logic                  wait_cnt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [1:0]            rd_pipe;
  logic [ADDR_WIDTH-1:0] idx_pipe0;
  logic [ADDR_WIDTH-1:0] idx_pipe1;
  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;

  logic                  push;
  logic                  pop;
  logic [CW-1:0]         count_next;
  logic [CW+1:0]         credit_sum;
  logic                  credit;
  logic [EW-1:0]         head;

  // Handshake: a beat moves when out_valid && out_ready; out_valid never drops without a pop.
  // Credit is judged for the cycle the read will be issued in: FIFO level after this edge
  // plus reads from that cycle's previous two cycles (rd_pipe[0] and the current cell_rden).
  always_comb begin
    push       = rd_pipe[1];
    pop        = out_valid & out_ready;
    count_next = fifo_count + CW'(push) - CW'(pop);
    credit_sum = (CW+2)'(count_next) + (CW+2)'(rd_pipe[0]) + (CW+2)'(cell_rden);
    credit     = credit_sum < DEPTH_V;
    head       = fifo_mem[rd_ptr];
  end

  assign cell_wren = 1'b0;
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_index = out_valid ? head[EW-1:DATA_WIDTH] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= 1'b0;
      next_addr    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      particle_num <= '0;
      cell_address <= '0;
      cell_rden    <= 1'b0;
    end else begin
      done      <= 1'b0;
      cell_rden <= 1'b0;
      case (state)
        IDLE: begin
          // done is still high in the cycle a stream finishes; a start there is dropped
          if (start && !done) begin
            state        <= RD_NUM;
            busy         <= 1'b1;
            cell_rden    <= 1'b1;
            cell_address <= '0;
          end
        end
        RD_NUM: begin
          state    <= WAIT_NUM;
          wait_cnt <= 1'b0;
        end
        WAIT_NUM: begin
          if (!wait_cnt) begin
            wait_cnt <= 1'b1;
          end else begin
            particle_num <= cell_q[ADDR_WIDTH-1:0];
            if (cell_q[ADDR_WIDTH-1:0] == '0) begin
              // nothing can be in flight, so the drain condition already holds
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // FIFO is empty here, so the first particle read always has credit
              cell_rden    <= 1'b1;
              cell_address <= ADDR_WIDTH'(1);
              next_addr    <= ADDR_WIDTH'(2);
              state        <= (cell_q[ADDR_WIDTH-1:0] == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
            end
          end
        end
        STREAM: begin
          if (credit) begin
            cell_rden    <= 1'b1;
            cell_address <= next_addr;
            if (next_addr == particle_num) state <= DRAIN;
            else                           next_addr <= next_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (count_next == '0 && !rd_pipe[0] && !cell_rden) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return tracking: only particle reads (issued in STREAM/DRAIN) land in the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe   <= 2'b00;
      idx_pipe0 <= '0;
      idx_pipe1 <= '0;
    end else begin
      rd_pipe   <= {rd_pipe[0], cell_rden && (state == STREAM || state == DRAIN)};
      idx_pipe0 <= cell_address;
      idx_pipe1 <= idx_pipe0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      fifo_count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {idx_pipe1, cell_q};
  end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Bench for cell_pos_reader: behavioural 2-cycle RAM, table of cell scenarios,
// beat scoreboard and an externally derived FIFO occupancy model.
module tb_cell_pos_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int FIFO_DEPTH = 4;
  localparam logic [DW-1:0] JUNK = {3{32'hDEAD_BEEF}};

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] particle_num;
  logic [AW-1:0] cell_address;
  logic          cell_rden;
  logic          cell_wren;
  logic [DW-1:0] cell_q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;

  cell_pos_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_num(particle_num), .cell_address(cell_address), .cell_rden(cell_rden),
    .cell_wren(cell_wren), .cell_q(cell_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // position RAM with 2-cycle read latency
  logic [DW-1:0] mem [256];
  logic [DW-1:0] q_s1;
  always @(posedge clk) begin
    q_s1   <= cell_rden ? mem[cell_address] : JUNK;
    cell_q <= q_s1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard and logs
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_idx_q[$];
  int rd_cyc_q[$];
  int rd_addr_q[$];
  int beat_cyc_q[$];
  int occ = 0;
  logic h1 = 1'b0;
  logic h2 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      occ <= 0;
      h1  <= 1'b0;
      h2  <= 1'b0;
    end else begin
      chk("valid_vs_model", out_valid, occ != 0);
      chk("fifo_bound", occ <= FIFO_DEPTH, 1'b1);
      if (cell_rden) begin
        rd_cyc_q.push_back(cyc - t0);
        rd_addr_q.push_back(int'(cell_address));
      end
      if (out_valid && out_ready) begin
        beat_cyc_q.push_back(cyc - t0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got index %0d, expected no beat", out_index);
        end else begin
          chk("beat_data", out_data, exp_q[0]);
          chk("beat_index", out_index, exp_idx_q[0]);
          void'(exp_q.pop_front());
          void'(exp_idx_q.pop_front());
        end
      end
      occ <= occ + int'(h2) - int'(out_valid && out_ready);
      h2  <= h1;
      h1  <= cell_rden && (cell_address != '0);
    end
  end

  // scenario table: mode 0 ready=1, 1 random ready + mid-run start,
  // 2 stall in cycles 5..20, 3 ready=1 with start pulsed in the done cycle
  typedef struct {
    logic [31:0] cnt;
    int          n;
    int          mode;
    int          exp_done;
  } vec_t;
  vec_t vecs[8];

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return !(c >= 5 && c <= 20);
    return 1'b1;
  endfunction

  task automatic load_cell(input logic [31:0] cnt, input int n);
    mem[0] = {$urandom, $urandom, cnt};
    for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    exp_q.delete();
    exp_idx_q.delete();
    for (int i = 1; i <= n; i++) begin
      exp_q.push_back(mem[i]);
      exp_idx_q.push_back(AW'(i));
    end
    rd_cyc_q.delete();
    rd_addr_q.delete();
    beat_cyc_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int c, done_rel, busy_cnt, zero_reads, part_reads;
    bit seen, ok;
    load_cell(v.cnt, v.n);
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b1;
    out_ready = ready_for(v.mode, 0);
    c = 0; seen = 0; busy_cnt = 0; done_rel = -1;
    while (!seen && c < 3000) begin
      @(negedge clk);
      if (c > 0 && busy) busy_cnt++;
      if (c > 0 && done) begin
        seen = 1;
        done_rel = c;
      end
      if (v.mode == 2 && c == 20) begin
        ok = (rd_addr_q.size() == 5);
        for (int i = 1; i < rd_addr_q.size() && i < 5; i++) ok &= (rd_addr_q[i] == i);
        chk("stall_reads", ok, 1'b1);
        chk("stall_head", {out_valid, out_index}, {1'b1, 8'd1});
      end
      if (!seen) begin
        @(posedge clk);
        #1;
        c++;
        start = (v.mode == 1 && c == 40) || (v.mode == 3 && c == v.exp_done);
        out_ready = ready_for(v.mode, c);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within 3000 cycles, expected done (n=%0d)", v.n);
    end
    if (v.exp_done >= 0) chk("done_cycle", done_rel, v.exp_done);
    chk("busy_span", busy_cnt, done_rel - 1);
    chk("particle_num", particle_num, v.n);
    chk("all_beats", exp_q.size(), 0);
    zero_reads = 0;
    part_reads = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] == 0) zero_reads++; else part_reads++;
    chk("count_reads", zero_reads, 1);
    chk("particle_reads", part_reads, v.n);
    if (rd_cyc_q.size() > 0) chk("count_read_cycle", {rd_cyc_q[0], rd_addr_q[0]}, {32'd1, 32'd0});
    if (v.mode == 0 || v.mode == 3) begin
      ok = (rd_cyc_q.size() == v.n + 1);
      for (int k = 1; k < rd_cyc_q.size(); k++) ok &= (rd_cyc_q[k] == 3 + k) && (rd_addr_q[k] == k);
      chk("read_timing", ok, 1'b1);
      ok = (beat_cyc_q.size() == v.n);
      for (int k = 0; k < beat_cyc_q.size(); k++) ok &= (beat_cyc_q[k] == 7 + k);
      chk("beat_timing", ok, 1'b1);
    end
    if (v.mode == 2) begin
      ok = 0;
      foreach (rd_addr_q[i]) if (rd_addr_q[i] == 5) ok = (rd_cyc_q[i] == 22);
      chk("stall_resume", ok, 1'b1);
      if (beat_cyc_q.size() > 0) chk("done_after_last", done_rel, beat_cyc_q[$] + 1);
    end
    exp_q.delete();
    exp_idx_q.delete();
  endtask

  task automatic reset_mid();
    bit quiet;
    load_cell(32'd20, 20);
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b1;
    out_ready = 1'b1;
    repeat (9) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("reset_mid_outputs",
        {busy, done, particle_num, cell_address, cell_rden, cell_wren, out_valid, out_data, out_index}, '0);
    @(negedge clk);
    exp_q.delete();
    exp_idx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    quiet = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy || cell_rden || done) quiet = 1'b1;
    end
    chk("post_reset_quiet", quiet, 1'b0);
    chk("post_reset_num", particle_num, 0);
  endtask

  initial begin
    vecs[0] = '{cnt: 32'd3,         n: 3,   mode: 0, exp_done: 10};
    vecs[1] = '{cnt: 32'd0,         n: 0,   mode: 0, exp_done: 4};
    vecs[2] = '{cnt: 32'h0000_0101, n: 1,   mode: 0, exp_done: 8};
    vecs[3] = '{cnt: 32'd10,        n: 10,  mode: 2, exp_done: 31};
    vecs[4] = '{cnt: 32'd219,       n: 219, mode: 1, exp_done: -1};
    vecs[5] = '{cnt: 32'd2,         n: 2,   mode: 3, exp_done: 9};
    vecs[6] = '{cnt: 32'd5,         n: 5,   mode: 0, exp_done: 12};
    vecs[7] = '{cnt: 32'h0000_0300, n: 0,   mode: 0, exp_done: 4};

    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("reset_outputs",
        {busy, done, particle_num, cell_address, cell_rden, cell_wren, out_valid, out_data, out_index}, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    reset_mid();
    run_vec(vecs[0]);
    chk("wren_low", cell_wren, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
